cla_pipe_adder: RTL and testbench



---
 rtl/cla_pkg.sv | 16 +
 rtl/cla_group.sv | 46 ++++
 rtl/cla_pipe_adder.sv | 125 ++++++++++++
 tb/tb_cla_pipe_adder.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder.
package cla_pkg;

  localparam int unsigned GROUP_DEFAULT = 4;

  // Group-level generate/propagate pair
  typedef struct packed {
    logic g;
    logic p;
  } gp_t;

  function automatic int unsigned nstage(input int unsigned width, input int unsigned group);
    return width / group;
  endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational GROUP-bit carry-lookahead block: sum, carry-out and group G/P.
module cla_group
  import cla_pkg::*;
#(
  parameter int unsigned GROUP = GROUP_DEFAULT
) (
  input  logic [GROUP-1:0] a,
  input  logic [GROUP-1:0] b,
  input  logic             cin,
  output logic [GROUP-1:0] s,
  output logic             cout,
  output gp_t              gp
);

  logic [GROUP-1:0] g;
  logic [GROUP-1:0] p;
  logic [GROUP:0]   c;
  logic             gacc;
  logic             pacc;

  assign g = a & b;
  assign p = a ^ b;

  // Every carry is built from the prefix G/P of the bits below it, so no
  // carry depends on another carry.
  always_comb begin
    gacc = 1'b0;
    pacc = 1'b1;
    c    = '0;
    c[0] = cin;
    for (int unsigned i = 0; i < GROUP; i++) begin
      gacc = 1'b0;
      pacc = 1'b1;
      for (int unsigned j = 0; j <= i; j++) begin
        gacc = g[j] | (p[j] & gacc);
        pacc = pacc & p[j];
      end
      c[i+1] = gacc | (pacc & cin);
    end
    gp = '{g: gacc, p: pacc};
  end

  assign s    = p ^ c[GROUP-1:0];
  assign cout = c[GROUP];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined CLA adder/subtractor, one GROUP-bit lookahead group per stage,
// valid/ready on both sides. Define CLA_OVF_EN to add the signed-overflow port ovf.
module cla_pipe_adder
  import cla_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned GROUP = GROUP_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout
`ifdef CLA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NSTAGE = nstage(WIDTH, GROUP);

  if ((WIDTH % GROUP) != 0 || WIDTH < GROUP) begin : g_bad_cfg
    $error("cla_pipe_adder: WIDTH must be a nonzero multiple of GROUP");
  end

  logic                          en;
  logic [WIDTH-1:0]              be;
  logic                          ce;
  logic [NSTAGE-1:0]             vld_q;
  logic [NSTAGE-1:0]             c_q;
  logic [NSTAGE-1:0][WIDTH-1:0]  a_q;
  logic [NSTAGE-1:0][WIDTH-1:0]  b_q;
  logic [NSTAGE-1:0][WIDTH-1:0]  s_q;
  logic [NSTAGE-1:0][WIDTH-1:0]  stage_s;
  logic [NSTAGE-1:0][GROUP-1:0]  grp_a;
  logic [NSTAGE-1:0][GROUP-1:0]  grp_b;
  logic [NSTAGE-1:0][GROUP-1:0]  grp_s;
  logic [NSTAGE-1:0]             grp_cin;
  logic [NSTAGE-1:0]             grp_c;
  gp_t  [NSTAGE-1:0]             grp_gp;
  logic                          unused_tail;

  assign en       = !out_valid || out_ready;
  assign in_ready = en;
  assign be       = b ^ {WIDTH{sub}};
  assign ce       = cin ^ sub;

  for (genvar k = 0; k < NSTAGE; k++) begin : g_stage
    localparam int unsigned LO = k * GROUP;
    if (k == 0) begin : g_first
      assign grp_a[k]   = a[LO +: GROUP];
      assign grp_b[k]   = be[LO +: GROUP];
      assign grp_cin[k] = ce;
      assign stage_s[k] = WIDTH'(grp_s[k]);
    end else begin : g_next
      assign grp_a[k]   = a_q[k-1][LO +: GROUP];
      assign grp_b[k]   = b_q[k-1][LO +: GROUP];
      assign grp_cin[k] = c_q[k-1];
      // Bits above the completed groups are still zero from stage 0
      assign stage_s[k] = s_q[k-1] | (WIDTH'(grp_s[k]) << LO);
    end

    cla_group #(.GROUP(GROUP)) u_group (
      .a    (grp_a[k]),
      .b    (grp_b[k]),
      .cin  (grp_cin[k]),
      .s    (grp_s[k]),
      .cout (grp_c[k]),
      .gp   (grp_gp[k])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      c_q   <= '0;
      a_q   <= '0;
      b_q   <= '0;
      s_q   <= '0;
    end else if (en) begin
      vld_q[0] <= in_valid;
      a_q[0]   <= a;
      b_q[0]   <= be;
      for (int unsigned k = 1; k < NSTAGE; k++) begin
        vld_q[k] <= vld_q[k-1];
        a_q[k]   <= a_q[k-1];
        b_q[k]   <= b_q[k-1];
      end
      s_q <= stage_s;
      c_q <= grp_c;
    end
  end

  assign out_valid = vld_q[NSTAGE-1];
  assign s         = s_q[NSTAGE-1];
  assign cout      = c_q[NSTAGE-1];

  // Last-stage operand copies and group G/P have no consumer
  assign unused_tail = ^{a_q[NSTAGE-1], b_q[NSTAGE-1], grp_gp};

`ifdef CLA_OVF_EN
  logic ovf_q;
  logic msb_cin;

  assign msb_cin = grp_s[NSTAGE-1][GROUP-1] ^ grp_a[NSTAGE-1][GROUP-1] ^ grp_b[NSTAGE-1][GROUP-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (en) begin
      ovf_q <= msb_cin ^ grp_c[NSTAGE-1];
    end
  end

  assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder: arithmetic reference model plus scoreboard queue.
module tb_cla_pipe_adder;

  localparam int W  = 16;
  localparam int G  = 4;
  localparam int NS = W / G;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid, in_ready, cin, sub, out_valid, out_ready, cout;
  logic [W-1:0] a, b, s;
`ifdef CLA_OVF_EN
  logic         ovf;
`endif

  int checks   = 0;
  int failures = 0;
  logic [17:0] expq[$];

  always #5 clk = ~clk;

  cla_pipe_adder #(.WIDTH(W), .GROUP(G)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .s         (s),
    .cout      (cout)
`ifdef CLA_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  // Returns {ovf, cout, s} from plain integer arithmetic
  function automatic logic [17:0] model(input logic [W-1:0] ta, input logic [W-1:0] tb,
                                        input logic tc, input logic ts);
    longint ua, ub, uc, sa, sb, usum, ssum;
    logic   o;
    ua   = longint'(ta);
    ub   = ts ? (longint'(65535) - longint'(tb)) : longint'(tb);
    uc   = (tc != ts) ? 1 : 0;
    usum = ua + ub + uc;
    sa   = (ua >= 32768) ? ua - 65536 : ua;
    sb   = (ub >= 32768) ? ub - 65536 : ub;
    ssum = sa + sb + uc;
    o    = (ssum > 32767) || (ssum < -32768);
    return {o, (usum >= 65536), 16'(usum % 65536)};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor, sampling mid-cycle
  logic         prev_stall = 1'b0;
  logic [W-1:0] prev_s;
  logic         prev_cout;
  always @(negedge clk) begin
    logic [17:0] e;
    if (!rst_n) begin
      expq.delete();
      chk("rst_out_valid", {31'b0, out_valid}, 0);
      chk("rst_s", {16'b0, s}, 0);
      chk("rst_cout", {31'b0, cout}, 0);
      chk("rst_in_ready", {31'b0, in_ready}, 1);
      prev_stall = 1'b0;
    end else begin
      chk("in_ready_rule", {31'b0, in_ready}, {31'b0, (!out_valid || out_ready)});
      if (prev_stall) begin
        chk("stall_valid_hold", {31'b0, out_valid}, 1);
        chk("stall_s_hold", {16'b0, s}, {16'b0, prev_s});
        chk("stall_cout_hold", {31'b0, cout}, {31'b0, prev_cout});
      end
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL spurious_result actual=%0h required=none", s);
        end else begin
          e = expq.pop_front();
          chk("result_s", {16'b0, s}, {16'b0, e[15:0]});
          chk("result_cout", {31'b0, cout}, {31'b0, e[16]});
`ifdef CLA_OVF_EN
          chk("result_ovf", {31'b0, ovf}, {31'b0, e[17]});
`endif
        end
      end
      if (in_valid && in_ready) expq.push_back(model(a, b, cin, sub));
      prev_stall = out_valid && !out_ready;
      prev_s     = s;
      prev_cout  = cout;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic randomize_beat();
    a   = W'($urandom);
    b   = W'($urandom);
    cin = 1'($urandom);
    sub = 1'($urandom);
  endtask

  // One isolated beat on an empty pipeline, literal expectations and latency
  task automatic single(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tc, input logic ts, input logic [W-1:0] es,
                        input logic ec, input logic eo);
    int n;
    logic [17:0] m;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = ta; b = tb; cin = tc; sub = ts;
    tick();
    in_valid = 1'b0;
    randomize_beat();
    n = 0;
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    chk({nm, "_latency"}, n, NS - 1);
    chk({nm, "_s"}, {16'b0, s}, {16'b0, es});
    chk({nm, "_cout"}, {31'b0, cout}, {31'b0, ec});
`ifdef CLA_OVF_EN
    chk({nm, "_ovf"}, {31'b0, ovf}, {31'b0, eo});
`endif
    m = model(ta, tb, tc, ts);
    chk({nm, "_model"}, {14'b0, m}, {14'b0, eo, ec, es});
    tick();
  endtask

  initial begin
    int cyc, sent, n;
    logic acc;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    single("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    single("add_carry_chain", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    single("add_all_ones", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    single("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    single("sub_borrow", 16'h0009, 16'h0003, 1'b1, 1'b1, 16'h0005, 1'b1, 1'b0);
    single("ovf_add", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    single("ovf_sub", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Back-to-back stream of 8 beats with a 3-cycle output stall
    cyc = 0; sent = 0;
    randomize_beat();
    while (sent < 8 && cyc < 100) begin
      out_ready = !(cyc >= 5 && cyc < 8);
      in_valid  = 1'b1;
      @(negedge clk);
      acc = in_valid && in_ready;
      if (!out_ready) begin
        chk("stall_out_valid", {31'b0, out_valid}, 1);
        chk("stall_in_ready", {31'b0, in_ready}, 0);
      end
      tick();
      if (acc) begin
        sent++;
        randomize_beat();
      end
      cyc++;
    end
    chk("stream_sent", sent, 8);
    in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    while (expq.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    chk("stream_drained", expq.size(), 0);

    // Fill the pipeline under stall, then reset mid-cycle
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < NS; i++) begin
      randomize_beat();
      tick();
    end
    in_valid = 1'b0;
    chk("full_out_valid", {31'b0, out_valid}, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", {31'b0, out_valid}, 0);
    chk("async_rst_s", {16'b0, s}, 0);
    chk("async_rst_cout", {31'b0, cout}, 0);
    chk("async_rst_in_ready", {31'b0, in_ready}, 1);
    @(posedge clk);
    #2 rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("post_rst_idle", {31'b0, out_valid}, 0);
    single("post_rst_beat", 16'h00F0, 16'h0F10, 1'b1, 1'b0, 16'h1001, 1'b0, 1'b0);

    // Random traffic on both handshakes
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(9) < 7);
      out_ready = ($urandom_range(9) < 7);
      randomize_beat();
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    n = 0;
    while (expq.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    chk("random_drained", expq.size(), 0);
    tick();
    chk("final_idle", {31'b0, out_valid}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
